// File: rtl/pet2001_vram_pkg.sv
// pet2001_vram_pkg: shared state encoding and slot constants for the PET video RAM arbiter
package pet2001_vram_pkg;
    localparam int VRAM_AW = 11;
    localparam int VRAM_DW = 8;
    localparam logic [2:0] PH_FETCH = 3'd0;
    localparam logic [2:0] PH_GUARD = 3'd7;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} arb_state_t;
endpackage

// File: rtl/pet2001vram_slot.sv
// pet2001vram_slot: decodes the character phase into the video fetch window and the CPU block window
// PET_SNOW_EN: only the phase-7 lead-in blocks the CPU, so CPU accesses may collide with the fetch
module pet2001vram_slot
    import pet2001_vram_pkg::*;
(
    input  logic [2:0] hc_phase,
    input  logic       video_on,
    output logic       vid_win,
    output logic       blk
);
    assign vid_win = video_on & (hc_phase == PH_FETCH);
`ifdef PET_SNOW_EN
    assign blk = video_on & (hc_phase == PH_GUARD);
`else
    // phase 7 guards phase 0 so a two-clk access never reaches into the fetch slot
    assign blk = vid_win | (video_on & (hc_phase == PH_GUARD));
`endif
endmodule

// File: rtl/pet2001vram_arb.sv
// pet2001vram_arb: time-slot arbiter sharing the PET video RAM between the CPU and character fetch
// PET_SNOW_EN: CPU accesses landing in the fetch window overwrite video_data (original PET snow)
module pet2001vram_arb
    import pet2001_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_7mp,
    input  logic          ce_7mn,
    input  logic [2:0]    hc_phase,
    input  logic          video_on,
    input  logic [AW-1:0] video_addr,
    output logic [DW-1:0] video_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall
);
    arb_state_t    state;
    logic          vid_win;
    logic          blk;
    logic          accept;
    logic          rd_done;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] rdata_q;
    logic          unused_ce;

    // pixel enables only pace the video generator; slot timing comes from hc_phase
    assign unused_ce = ce_7mp ^ ce_7mn;

    pet2001vram_slot u_slot (
        .hc_phase (hc_phase),
        .video_on (video_on),
        .vid_win  (vid_win),
        .blk      (blk)
    );

    assign accept    = (state == IDLE) & cpu_req & ~blk;
    assign stall     = (state == IDLE) & cpu_req & blk;
    assign ram_addr  = (state == ACC) ? lat_addr : video_addr;
    assign ram_we    = (state == ACC) & lat_we;
    assign ram_wdata = lat_wdata;
    assign cpu_ack   = state == DONE;
    assign rd_done   = cpu_ack & ~lat_we;
    // read data passes straight through in the ack cycle and is held afterwards
    assign cpu_rdata = rd_done ? ram_rdata : rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= accept ? ACC : (state == ACC) ? DONE : IDLE;
            if (accept) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
            end
            if (rd_done) rdata_q <= ram_rdata;
        end
    end

`ifdef PET_SNOW_EN
    logic snow;

    // once the CPU has hit the fetch window its data stays on the video bus until the window ends
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_data <= '0;
            snow       <= 1'b0;
        end else if (!vid_win) begin
            snow <= 1'b0;
        end else if ((state == ACC) & lat_we) begin
            video_data <= lat_wdata;
            snow       <= 1'b1;
        end else if (rd_done) begin
            video_data <= ram_rdata;
            snow       <= 1'b1;
        end else if (!snow) begin
            video_data <= ram_rdata;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) video_data <= '0;
        else if (vid_win) video_data <= ram_rdata;
    end
`endif
endmodule

// File: tb/tb_pet2001vram_arb.sv
// tb_pet2001vram_arb: randomized CPU traffic against a slot-rule model and a reference copy of VRAM
module tb_pet2001vram_arb;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_7mp, ce_7mn;
    logic [2:0]  hc_phase;
    logic        video_on = 1'b0;
    logic [10:0] video_addr = '0;
    logic [7:0]  video_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        stall;

    logic [7:0]  mem [0:2047];
    logic [7:0]  ref_mem [0:2047];
    bit          mem_ok = 1'b0;
    logic [1:0]  k = '0;
    logic [2:0]  hc = '0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_vd = '0;
    bit          mon_en = 1'b0;
    logic [2:0]  ph;
    logic [1:0]  kk;
    logic [7:0]  rd;
    logic        r_we;
    logic [10:0] r_a;
    logic [7:0]  r_d;

    always #5 clk = ~clk;

    assign hc_phase = hc;
    assign ce_7mp   = k == 2'd3;
    assign ce_7mn   = k == 2'd2;

    pet2001vram_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce_7mp     (ce_7mp),
        .ce_7mn     (ce_7mn),
        .hc_phase   (hc_phase),
        .video_on   (video_on),
        .video_addr (video_addr),
        .video_data (video_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stall      (stall)
    );

    // VRAM block: synchronous read, one clk latency, preloaded from the reference copy
    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 2048; i++) mem[i] <= ref_mem[i];
            mem_ok <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // video timing: 4 clk per pixel phase, new character address at each phase 0
    initial forever begin
        @(posedge clk);
        #1;
        k = k + 2'd1;
        if (k == 2'd0) begin
            hc = hc + 3'd1;
            if (hc == 3'd0) video_addr = 11'($urandom_range(0, 31));
        end
    end

    // the fetched code must appear by ce_7mn of phase 0 and then hold
    initial forever begin
        @(negedge clk);
        if (mon_en && ce_7mn) begin
            if (video_on && hc_phase == 3'd0) begin
                exp_vd = ref_mem[video_addr];
                chk("vfetch", 32'(video_data), 32'(exp_vd));
            end else begin
                chk("vhold", 32'(video_data), 32'(exp_vd));
            end
        end
    end

    task automatic wait_for(input logic [2:0] p, input logic [1:0] q);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(hc_phase == p && k == q) && n < 100);
        if (n >= 100) chk("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic cpu_access(input logic we, input logic [10:0] a, input logic [7:0] d, input bit tog,
                              output logic [2:0] acc_ph, output logic [1:0] acc_k, output logic [7:0] rdat);
        int  acc = -1;
        int  wes = 0;
        bit  got = 1'b0;
        bit  blocked;
        acc_ph = '0;
        acc_k  = '0;
        rdat   = '0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            wes += int'(ram_we);
            blocked = video_on && (hc_phase == 3'd0 || hc_phase == 3'd7);
            if (acc < 0) begin
                chk("stall", 32'(stall), 32'(blocked));
                chk("early_ack", 32'(cpu_ack), 32'd0);
                if (!blocked) begin
                    acc = n;
                    acc_ph = hc_phase;
                    acc_k = k;
                end
            end else if (n == acc + 2) begin
                got = 1'b1;
                chk("ack", 32'(cpu_ack), 32'd1);
                chk("busy_stall", 32'(stall), 32'd0);
                if (!we) begin
                    rdat = cpu_rdata;
                    chk("rdata", 32'(cpu_rdata), 32'(ref_mem[a]));
                end
            end else begin
                chk("acc_ack", 32'(cpu_ack), 32'd0);
            end
            if (acc >= 0 && !got) begin
                @(posedge clk);
                #2;
                cpu_we = ~we;
                cpu_addr = ~a;
                cpu_wdata = ~d;
                if (tog) video_on = 1'b1;
            end
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("ack_once", 32'(cpu_ack), 32'd0);
        chk("we_pulses", 32'(wes), we ? 32'd1 : 32'd0);
        if (we) ref_mem[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
        ref_mem[11'h123] = 8'h41;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vdata", 32'(video_data), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_raddr", 32'(ram_addr), 32'(video_addr));
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        mon_en = 1'b1;

        wait_for(3'd2, 2'd0);
        cpu_access(1'b0, 11'h123, 8'h00, 1'b0, ph, kk, rd);
        chk("t1_rd", 32'(rd), 32'h41);
        chk("t1_acc", 32'({ph, kk}), 32'({3'd2, 2'd0}));

        wait_for(3'd6, 2'd0);
        video_on = 1'b1;
        wait_for(3'd7, 2'd0);
        cpu_access(1'b0, 11'h0AA, 8'h00, 1'b0, ph, kk, rd);
        chk("t2_ph", 32'(ph), 32'd1);
        chk("t2_k", 32'(kk), 32'd0);

        wait_for(3'd3, 2'd0);
        cpu_access(1'b1, 11'h7F5, 8'hA0, 1'b0, ph, kk, rd);
        wait_for(3'd4, 2'd0);
        cpu_access(1'b0, 11'h7F5, 8'h00, 1'b0, ph, kk, rd);
        chk("t3_rb", 32'(rd), 32'hA0);

        wait_for(3'd6, 2'd0);
        video_on = 1'b0;
        wait_for(3'd5, 2'd3);
        cpu_access(1'b1, 11'h010, 8'h5C, 1'b1, ph, kk, rd);
        wait_for(3'd2, 2'd0);
        cpu_access(1'b0, 11'h010, 8'h00, 1'b0, ph, kk, rd);
        chk("t4_rb", 32'(rd), 32'h5C);

        wait_for(3'd6, 2'd0);
        video_on = 1'b0;
        wait_for(3'd2, 2'd0);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 11'h020;
        cpu_wdata = ~ref_mem[11'h020];
        @(negedge clk);
        @(negedge clk);
        chk("mid_we", 32'(ram_we), 32'd1);
        #1;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_we_off", 32'(ram_we), 32'd0);
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_ack", 32'(cpu_ack), 32'd0);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        exp_vd = '0;
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_ack", 32'(cpu_ack), 32'd0);
            chk("post_we", 32'(ram_we), 32'd0);
        end
        wait_for(3'd1, 2'd0);
        cpu_access(1'b0, 11'h020, 8'h00, 1'b0, ph, kk, rd);

        for (int it = 0; it < 60; it++) begin
            wait_for(3'd6, 2'd0);
            if ($urandom_range(0, 3) == 0) video_on = ~video_on;
            wait_for(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            r_we = 1'($urandom_range(0, 1));
            r_a = 11'($urandom_range(0, 31));
            r_d = 8'($urandom);
            cpu_access(r_we, r_a, r_d, 1'b0, ph, kk, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
